// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// id_ex_stage_pkg : shared pipeline definitions (control bundle, bubble, update kinds)
// Rev 1.0
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int c_ALUOP_W = 4;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 alu_src;
    logic                 reg_dst_sel;
    logic [c_ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam int    c_CTRL_W      = $bits(ctrl_t);
  localparam ctrl_t c_CTRL_BUBBLE = '0;

  // What the ID/EX register does on the coming edge, highest priority first.
  typedef enum logic [2:0] {
    UPD_RESET = 3'd0,
    UPD_FLUSH = 3'd1,
    UPD_HOLD  = 3'd2,
    UPD_STALL = 3'd3,
    UPD_LOAD  = 3'd4
  } upd_t;

  function automatic logic [4:0] resolve_dst(input logic       sel,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd);
    return sel ? rd : rt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_hazard.sv
// ============================================================================
// Hazard_Detect_Unit : combinational load-use detector between ID/EX and ID
// Rev 1.0
// ============================================================================
`default_nettype none

module Hazard_Detect_Unit
  import id_ex_stage_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_dst,
  input  logic       i_id_valid,
  input  logic       i_id_uses_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  output logic       o_load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_ex_dst == i_id_rs);
  assign w_rt_hit = i_id_uses_rt && (i_ex_dst == i_id_rt);

  // $0 is never really written, so a load targeting it cannot be a producer.
  assign o_load_use = i_ex_valid && i_ex_mem_read && (i_ex_dst != 5'd0) &&
                      i_id_valid && (w_rs_hit || w_rt_hit);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with flush/hold/load-use stall control
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter logic [15:0] STALL_SAT_MAX = 16'hFFFF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [4:0]           ID_Rs,
  input  logic [4:0]           ID_Rt,
  input  logic [4:0]           ID_Rd,
  input  logic                 ID_UsesRt,
  input  logic [31:0]          ID_ReadData1,
  input  logic [31:0]          ID_ReadData2,
  input  logic [31:0]          ID_Imm,
  input  logic [31:0]          ID_PCPlus4,
  input  logic                 ID_RegWrite,
  input  logic                 ID_MemRead,
  input  logic                 ID_MemWrite,
  input  logic                 ID_MemToReg,
  input  logic                 ID_ALUSrc,
  input  logic                 ID_RegDstSel,
  input  logic [c_ALUOP_W-1:0] ID_ALUOp,
  input  logic                 ID_Valid,
  input  logic                 Flush,
  input  logic                 Hold,
  output logic [4:0]           ID_EX_RegisterRs,
  output logic [4:0]           ID_EX_RegisterRt,
  output logic [4:0]           ID_EX_RegDst,
  output logic [31:0]          ID_EX_ReadData1,
  output logic [31:0]          ID_EX_ReadData2,
  output logic [31:0]          ID_EX_Imm,
  output logic [31:0]          ID_EX_PCPlus4,
  output logic                 ID_EX_RegWrite,
  output logic                 ID_EX_MemRead,
  output logic                 ID_EX_MemWrite,
  output logic                 ID_EX_MemToReg,
  output logic                 ID_EX_ALUSrc,
  output logic                 ID_EX_RegDstSel,
  output logic [c_ALUOP_W-1:0] ID_EX_ALUOp,
  output logic                 ID_EX_Valid,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic [15:0]          StallCount
);

  ctrl_t       r_ctrl;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_dst;
  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic [31:0] r_imm;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [15:0] r_stall_count;

  ctrl_t       w_id_ctrl;
  logic        w_load_use;
  logic        w_front_write;
  upd_t        w_upd;

  assign w_id_ctrl = {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
                      ID_ALUSrc, ID_RegDstSel, ID_ALUOp};

  Hazard_Detect_Unit u_hazard (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_dst      (r_dst),
    .i_id_valid    (ID_Valid),
    .i_id_uses_rt  (ID_UsesRt),
    .i_id_rs       (ID_Rs),
    .i_id_rt       (ID_Rt),
    .o_load_use    (w_load_use)
  );

  always_comb begin
    w_upd = UPD_LOAD;
    if (Rst)             w_upd = UPD_RESET;
    else if (Flush)      w_upd = UPD_FLUSH;
    else if (Hold)       w_upd = UPD_HOLD;
    else if (w_load_use) w_upd = UPD_STALL;
  end

  // Front end only freezes while this register itself is frozen or bubbling for a load.
  assign w_front_write = (w_upd != UPD_HOLD) && (w_upd != UPD_STALL);
  assign PCWrite       = w_front_write;
  assign IF_ID_Write   = w_front_write;

  always_ff @(posedge Clk) begin
    case (w_upd)
      UPD_RESET, UPD_FLUSH, UPD_STALL: begin
        r_ctrl  <= c_CTRL_BUBBLE;
        r_rs    <= '0;
        r_rt    <= '0;
        r_dst   <= '0;
        r_rd1   <= '0;
        r_rd2   <= '0;
        r_imm   <= '0;
        r_pc4   <= '0;
        r_valid <= 1'b0;
      end
      UPD_HOLD: begin
      end
      default: begin
        r_ctrl  <= ID_Valid ? w_id_ctrl : c_CTRL_BUBBLE;
        r_rs    <= ID_Rs;
        r_rt    <= ID_Rt;
        r_dst   <= resolve_dst(ID_RegDstSel, ID_Rt, ID_Rd);
        r_rd1   <= ID_ReadData1;
        r_rd2   <= ID_ReadData2;
        r_imm   <= ID_Imm;
        r_pc4   <= ID_PCPlus4;
        r_valid <= ID_Valid;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (w_upd == UPD_RESET) begin
      r_stall_count <= '0;
    end else if (w_upd == UPD_STALL && r_stall_count != STALL_SAT_MAX) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign ID_EX_RegisterRs = r_rs;
  assign ID_EX_RegisterRt = r_rt;
  assign ID_EX_RegDst     = r_dst;
  assign ID_EX_ReadData1  = r_rd1;
  assign ID_EX_ReadData2  = r_rd2;
  assign ID_EX_Imm        = r_imm;
  assign ID_EX_PCPlus4    = r_pc4;
  assign ID_EX_RegWrite   = r_ctrl.reg_write;
  assign ID_EX_MemRead    = r_ctrl.mem_read;
  assign ID_EX_MemWrite   = r_ctrl.mem_write;
  assign ID_EX_MemToReg   = r_ctrl.mem_to_reg;
  assign ID_EX_ALUSrc     = r_ctrl.alu_src;
  assign ID_EX_RegDstSel  = r_ctrl.reg_dst_sel;
  assign ID_EX_ALUOp      = r_ctrl.alu_op;
  assign ID_EX_Valid      = r_valid;
  assign StallCount       = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : randomized + directed scoreboard bench for id_ex_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam logic [15:0] SAT = 16'd40;
  localparam logic [9:0]  LW  = 10'b1_1_0_1_1_0_0000;
  localparam logic [9:0]  ADD = 10'b1_0_0_0_0_1_0010;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [4:0]  ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
  logic        ID_UsesRt = 1'b0;
  logic [31:0] ID_ReadData1 = '0, ID_ReadData2 = '0, ID_Imm = '0, ID_PCPlus4 = '0;
  logic        ID_RegWrite = 1'b0, ID_MemRead = 1'b0, ID_MemWrite = 1'b0;
  logic        ID_MemToReg = 1'b0, ID_ALUSrc = 1'b0, ID_RegDstSel = 1'b0;
  logic [3:0]  ID_ALUOp = '0;
  logic        ID_Valid = 1'b0, Flush = 1'b0, Hold = 1'b0;
  logic [4:0]  ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegDst;
  logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PCPlus4;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg;
  logic        ID_EX_ALUSrc, ID_EX_RegDstSel, ID_EX_Valid, PCWrite, IF_ID_Write;
  logic [3:0]  ID_EX_ALUOp;
  logic [15:0] StallCount;

  always #5 Clk = ~Clk;

  id_ex_stage #(.STALL_SAT_MAX(SAT)) dut (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_UsesRt(ID_UsesRt), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_PCPlus4(ID_PCPlus4), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg),
    .ID_ALUSrc(ID_ALUSrc), .ID_RegDstSel(ID_RegDstSel), .ID_ALUOp(ID_ALUOp),
    .ID_Valid(ID_Valid), .Flush(Flush), .Hold(Hold),
    .ID_EX_RegisterRs(ID_EX_RegisterRs), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_ReadData1(ID_EX_ReadData1),
    .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_Imm(ID_EX_Imm), .ID_EX_PCPlus4(ID_EX_PCPlus4),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemToReg(ID_EX_MemToReg),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_RegDstSel(ID_EX_RegDstSel),
    .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_Valid(ID_EX_Valid), .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write), .StallCount(StallCount)
  );

  // ctrl bit order: RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDstSel, ALUOp[3:0]
  typedef struct packed {
    logic rst, flush, hold, id_valid, uses_rt;
    logic [4:0] rs, rt, rd;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [9:0] ctrl;
  } stim_t;

  typedef struct packed {
    logic valid;
    logic [9:0] ctrl;
    logic [4:0] rs, rt, dst;
    logic [31:0] rd1, rd2, imm, pc4;
  } pipe_t;

  typedef struct packed {
    logic pcw;
    pipe_t regs;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  pipe_t       m_reg = '0;
  logic [15:0] m_cnt = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model: what the pipeline register should hold after the coming edge.
  task automatic drive(input stim_t s);
    pipe_t nxt;
    logic [15:0] ncnt;
    logic pcw, lu;
    exp_t e;
    @(negedge Clk);
    Rst = s.rst; Flush = s.flush; Hold = s.hold; ID_Valid = s.id_valid;
    ID_UsesRt = s.uses_rt; ID_Rs = s.rs; ID_Rt = s.rt; ID_Rd = s.rd;
    ID_ReadData1 = s.rd1; ID_ReadData2 = s.rd2; ID_Imm = s.imm; ID_PCPlus4 = s.pc4;
    {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDstSel, ID_ALUOp} = s.ctrl;
    lu = m_reg.valid && m_reg.ctrl[8] && (m_reg.dst != 5'd0) && s.id_valid &&
         ((m_reg.dst == s.rs) || (s.uses_rt && (m_reg.dst == s.rt)));
    nxt = m_reg; ncnt = m_cnt; pcw = 1'b1;
    if (s.rst) begin
      nxt = '0; ncnt = '0;
    end else if (s.flush) begin
      nxt = '0;
    end else if (s.hold) begin
      pcw = 1'b0;
    end else if (lu) begin
      nxt = '0; pcw = 1'b0;
      if (m_cnt < SAT) ncnt = m_cnt + 16'd1;
    end else begin
      nxt.valid = s.id_valid;
      nxt.ctrl  = s.id_valid ? s.ctrl : 10'd0;
      nxt.rs = s.rs; nxt.rt = s.rt;
      nxt.dst = s.ctrl[4] ? s.rd : s.rt;
      nxt.rd1 = s.rd1; nxt.rd2 = s.rd2; nxt.imm = s.imm; nxt.pc4 = s.pc4;
    end
    e.pcw = pcw; e.regs = nxt; e.cnt = ncnt;
    sb_q.push_back(e);
    m_reg = nxt; m_cnt = ncnt;
  endtask

  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic uses_rt,
                               input logic [9:0] ctrl);
    stim_t s;
    s = '0;
    s.id_valid = 1'b1; s.uses_rt = uses_rt; s.rs = rs; s.rt = rt; s.rd = rd; s.ctrl = ctrl;
    s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom; s.pc4 = $urandom;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 10'($urandom));
    s.rst      = ($urandom_range(0, 63) == 0);
    s.flush    = ($urandom_range(0, 15) == 0);
    s.hold     = ($urandom_range(0, 7) == 0);
    s.id_valid = ($urandom_range(0, 7) != 0);
    return s;
  endfunction

  exp_t  mon_e;
  pipe_t act;

  initial begin
    forever begin
      @(negedge Clk);
      #2;
      if (sb_q.size() > 0) begin
        mon_e = sb_q[0];
        n_cmp++;
        if (PCWrite !== mon_e.pcw || IF_ID_Write !== mon_e.pcw) begin
          n_bad++;
          $display("FAIL pcwrite t=%0t: PCWrite=%b IF_ID_Write=%b expected %b",
                   $time, PCWrite, IF_ID_Write, mon_e.pcw);
        end
        @(posedge Clk);
        #1;
        mon_e = sb_q.pop_front();
        act.valid = ID_EX_Valid;
        act.ctrl  = {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
                     ID_EX_ALUSrc, ID_EX_RegDstSel, ID_EX_ALUOp};
        act.rs = ID_EX_RegisterRs; act.rt = ID_EX_RegisterRt; act.dst = ID_EX_RegDst;
        act.rd1 = ID_EX_ReadData1; act.rd2 = ID_EX_ReadData2;
        act.imm = ID_EX_Imm; act.pc4 = ID_EX_PCPlus4;
        n_cmp++;
        if (act !== mon_e.regs) begin
          n_bad++;
          $display("FAIL idex_regs t=%0t: got v=%b ctrl=%h rs=%0d rt=%0d dst=%0d d1=%h d2=%h imm=%h pc4=%h expected v=%b ctrl=%h rs=%0d rt=%0d dst=%0d d1=%h d2=%h imm=%h pc4=%h",
                   $time, act.valid, act.ctrl, act.rs, act.rt, act.dst, act.rd1, act.rd2,
                   act.imm, act.pc4, mon_e.regs.valid, mon_e.regs.ctrl, mon_e.regs.rs,
                   mon_e.regs.rt, mon_e.regs.dst, mon_e.regs.rd1, mon_e.regs.rd2,
                   mon_e.regs.imm, mon_e.regs.pc4);
        end
        n_cmp++;
        if (StallCount !== mon_e.cnt) begin
          n_bad++;
          $display("FAIL stallcount t=%0t: got %0d expected %0d", $time, StallCount, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    stim_t s;
    s = mk(5'd0, 5'd0, 5'd0, 1'b0, 10'd0);
    s.rst = 1'b1;
    drive(s); drive(s);
    // lw $8 then add $9,$8,$10: one bubble, then the add loads
    drive(mk(5'd2, 5'd8, 5'd0, 1'b0, LW));
    s = mk(5'd8, 5'd10, 5'd9, 1'b1, ADD);
    drive(s); drive(s);
    // load to $0 never stalls
    drive(mk(5'd0, 5'd0, 5'd0, 1'b0, LW));
    drive(mk(5'd0, 5'd4, 5'd6, 1'b1, ADD));
    // flush overrides load-use
    drive(mk(5'd1, 5'd8, 5'd0, 1'b0, LW));
    s = mk(5'd8, 5'd3, 5'd4, 1'b1, ADD); s.flush = 1'b1;
    drive(s);
    // hold freezes a captured RegDst of 5
    drive(mk(5'd1, 5'd2, 5'd5, 1'b1, ADD));
    repeat (3) begin
      s = mk(5'd7, 5'd7, 5'd9, 1'b1, LW); s.hold = 1'b1;
      drive(s);
    end
    // hold masks load-use until it drops; rt-side hazard
    drive(mk(5'd1, 5'd6, 5'd0, 1'b0, LW));
    s = mk(5'd2, 5'd6, 5'd3, 1'b1, ADD); s.hold = 1'b1;
    drive(s); drive(s);
    s.hold = 1'b0;
    drive(s); drive(s);
    // invalid ID instruction: no hazard, control forced off
    drive(mk(5'd1, 5'd6, 5'd0, 1'b0, LW));
    s = mk(5'd6, 5'd6, 5'd3, 1'b1, ADD); s.id_valid = 1'b0;
    drive(s);
    repeat (3000) drive(rand_stim());
    // saturation of the stall counter
    s = mk(5'd0, 5'd0, 5'd0, 1'b0, 10'd0); s.rst = 1'b1;
    drive(s);
    repeat (int'(SAT) + 5) begin
      drive(mk(5'd1, 5'd3, 5'd0, 1'b0, LW));
      drive(mk(5'd3, 5'd1, 5'd2, 1'b1, ADD));
    end
    // reset mid-stall beats flush and hold
    drive(mk(5'd1, 5'd3, 5'd0, 1'b0, LW));
    s = mk(5'd3, 5'd1, 5'd2, 1'b1, ADD);
    drive(s);
    s.rst = 1'b1; s.flush = 1'b1; s.hold = 1'b1;
    drive(s);
    s.rst = 1'b0; s.flush = 1'b0; s.hold = 1'b0;
    drive(s);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge Clk);
    #3;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: Clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: Rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: ID_Rs, ID_Rt, ID_Rd  in  5 each  decoded register fields of the instruction in ID.
REQ-004 SHALL: ID_UsesRt  in  1  ID instruction reads Rt as a source (R-type, store, branch).
REQ-005 SHALL: ID_ReadData1, ID_ReadData2, ID_Imm, ID_PCPlus4  in  32 each  ID operands, sign-extended immediate and PC+4.
REQ-006 SHALL: ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDstSel  in  1 each; ID_ALUOp  in  4  control bundle.
REQ-007 SHALL: ID_Valid  in  1  IF/ID holds a real instruction.
REQ-008 SHALL: Flush  in  1  branch mispredict from EX; squash the ID instruction.
REQ-009 SHALL: Hold  in  1  downstream memory stall; freeze this register.
REQ-010 SHALL: ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegDst  out  5 each  registered source fields and resolved destination.
REQ-011 SHALL: ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PCPlus4  out  32 each; ID_EX_<ctrl>  out  registered copies of REQ-006 bits; ID_EX_Valid  out  1.
REQ-012 SHALL: PCWrite, IF_ID_Write  out  1 each  combinational; 0 freezes PC and IF/ID.
REQ-013 SHALL: StallCount  out  16  load-use stall cycles, saturating.

Function
REQ-014 SHALL: ID_EX_RegDst be ID_Rd when ID_RegDstSel=1, else ID_Rt, captured at the same edge as the other fields.
REQ-015 SHALL: LoadUse = ID_EX_Valid & ID_EX_MemRead & (ID_EX_RegDst!=0) & ID_Valid & ((ID_EX_RegDst==ID_Rs) | (ID_UsesRt & ID_EX_RegDst==ID_Rt)).
REQ-016 SHALL: update priority per edge: Rst > Flush > Hold > LoadUse > Load.
REQ-017 SHALL: Flush: register loads a bubble (Valid, RegWrite, MemRead, MemWrite = 0, all other fields 0); PCWrite=IF_ID_Write=1; LoadUse ignored.
REQ-018 SHALL: Hold (no Flush): all register fields retain value; PCWrite=IF_ID_Write=0; StallCount unchanged.
REQ-019 SHALL: LoadUse (no Flush/Hold): register loads a bubble; PCWrite=IF_ID_Write=0; StallCount increments by 1.
REQ-020 SHALL: Load: all fields captured from ID inputs, ID_EX_Valid=ID_Valid; control bits forced 0 when ID_Valid=0; PCWrite=IF_ID_Write=1.
REQ-021 SHALL: load-use resolve in exactly one bubble: the cycle after the stall the load has left ID/EX, LoadUse deasserts and the consumer loads normally.
REQ-022 SHALL: StallCount saturate at 16'hFFFF (no wrap).
REQ-023 SHALL: Hold and LoadUse together: Hold wins; LoadUse re-evaluated once Hold drops.

Reset
REQ-024 SHALL: on Rst, all ID_EX_* outputs 0, ID_EX_Valid=0, StallCount=0, regardless of Flush/Hold.
REQ-025 SHALL: during Rst, PCWrite=IF_ID_Write=1; first instruction after Rst deasserts loads normally.

Structure
REQ-026 SHALL: ALUOp width, control-bundle width and bubble encoding be defined once in the shared pipeline defines include used by all stages.
REQ-027 SHALL: load-use detection be a separate combinational sub-module Hazard_Detect_Unit; the register, priority logic and counter remain in id_ex_stage.

Verification
REQ-028 SHALL: lw $8 in ID/EX, add $9,$8,$10 in ID (Rs=8) -> one cycle PCWrite=0, bubble in ID/EX, StallCount=1; next cycle add loads with ID_EX_RegisterRs=8.
REQ-029 SHALL: lw $0 in ID/EX, consumer Rs=0 -> no stall, StallCount=0.
REQ-030 SHALL: LoadUse condition with Flush=1 same cycle -> bubble, PCWrite=1, StallCount unchanged.
REQ-031 SHALL: Hold=1 for 3 cycles with ID_Rd=5, RegDstSel=1 captured -> ID_EX_RegDst stays 5, PCWrite=0 all 3 cycles.
REQ-032 SHALL: StallCount preset to 16'hFFFF via repeated stalls -> further LoadUse leaves 16'hFFFF.
REQ-033 SHALL: Rst asserted mid-stall -> next edge all outputs 0, ID_EX_Valid=0, StallCount=0.
